// File: rtl/countdown_timer.sv
// countdown_timer: loadable, restartable down-counter with a small control FSM.
// All state updates on the falling edge of NEclk. Reset is synchronous and
// active-low. A one-cycle terminal-count pulse (tc) marks each expiry; with
// auto_reload the counter reloads from the reload register and keeps running.
module countdown_timer #(
    parameter int BITS = 29
) (
    input  logic            NEclk,
    input  logic            reset,
    input  logic            Enable,
    input  logic            load,
    input  logic [BITS-1:0] load_value,
    input  logic            start,
    input  logic            pause,
    input  logic            auto_reload,
    output logic [BITS-1:0] count,
    output logic            tc,
    output logic            busy,
    output logic            expired
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    localparam logic [BITS-1:0] CNT_ZERO = {BITS{1'b0}};
    localparam logic [BITS-1:0] CNT_ONE  = {{(BITS-1){1'b0}}, 1'b1};

    logic [1:0]      state_r;
    logic [1:0]      state_nx_s;
    logic [BITS-1:0] count_r;
    logic [BITS-1:0] count_nx_s;
    logic [BITS-1:0] reload_r;
    logic [BITS-1:0] reload_nx_s;
    logic            tc_nx_s;
    logic            tc_r;
    logic            busy_r;
    logic            expired_r;

    // Next-state decode: load beats start/pause, which beat the Enable decrement.
    always_comb begin
        state_nx_s  = state_r;
        count_nx_s  = count_r;
        reload_nx_s = reload_r;
        tc_nx_s     = 1'b0;
        if (load) begin
            reload_nx_s = load_value;
            count_nx_s  = load_value;
            state_nx_s  = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // A zero period has nothing to count, so start is ignored.
                    if (start && (count_r != CNT_ZERO)) begin
                        state_nx_s = ST_RUN;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_nx_s = ST_PAUSED;
                    end else if (Enable) begin
                        // Expiry is caught at 1, so the count never wraps below 0.
                        if (count_r == CNT_ONE) begin
                            tc_nx_s = 1'b1;
                            if (auto_reload) begin
                                count_nx_s = reload_r;
                                state_nx_s = ST_RUN;
                            end else begin
                                count_nx_s = CNT_ZERO;
                                state_nx_s = ST_EXPIRED;
                            end
                        end else begin
                            count_nx_s = count_r - CNT_ONE;
                        end
                    end else begin
                        count_nx_s = count_r;
                    end
                end
                ST_PAUSED: begin
                    if (start && !pause) begin
                        state_nx_s = ST_RUN;
                    end else begin
                        state_nx_s = ST_PAUSED;
                    end
                end
                ST_EXPIRED: begin
                    if (start && (reload_r != CNT_ZERO)) begin
                        count_nx_s = reload_r;
                        state_nx_s = ST_RUN;
                    end else begin
                        count_nx_s = CNT_ZERO;
                        state_nx_s = ST_EXPIRED;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, count, reload and registered status flags; reset overrides everything.
    always_ff @(negedge NEclk) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            count_r   <= CNT_ZERO;
            reload_r  <= CNT_ZERO;
            tc_r      <= 1'b0;
            busy_r    <= 1'b0;
            expired_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            count_r   <= count_nx_s;
            reload_r  <= reload_nx_s;
            tc_r      <= tc_nx_s;
            busy_r    <= (state_nx_s == ST_RUN) || (state_nx_s == ST_PAUSED);
            expired_r <= (state_nx_s == ST_EXPIRED);
        end
    end

    assign count   = count_r;
    assign tc      = tc_r;
    assign busy    = busy_r;
    assign expired = expired_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer (BITS=8). The stimulus process drives
// inputs on the rising edge, predicts the outputs after the next falling edge
// with a behavioural model and queues them; a monitor pops and compares 1ns
// after every falling edge.
module tb_countdown_timer;

    localparam int BITS = 8;

    logic            NEclk;
    logic            reset;
    logic            Enable;
    logic            load;
    logic [BITS-1:0] load_value;
    logic            start;
    logic            pause;
    logic            auto_reload;
    logic [BITS-1:0] count;
    logic            tc;
    logic            busy;
    logic            expired;

    countdown_timer #(.BITS(BITS)) dut (
        .NEclk(NEclk), .reset(reset), .Enable(Enable), .load(load),
        .load_value(load_value), .start(start), .pause(pause),
        .auto_reload(auto_reload), .count(count), .tc(tc), .busy(busy),
        .expired(expired)
    );

    initial begin
        NEclk = 1'b1;
        forever #5 NEclk = ~NEclk;
    end

    typedef struct {
        logic [BITS-1:0] count;
        logic            tc;
        logic            busy;
        logic            expired;
        string           tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: timer mode as plain flags plus integers.
    typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_EXPIRED} mode_t;
    mode_t m_mode   = M_IDLE;
    int    m_count  = 0;
    int    m_reload = 0;

    // Issue one edge of stimulus and queue the predicted result.
    task automatic step(input logic rst, input logic ld, input int lv,
                        input logic st, input logic ps, input logic en,
                        input logic ar, input string tag);
        exp_t e;
        bit   pulse;
        @(posedge NEclk);
        reset = rst; load = ld; load_value = lv[BITS-1:0];
        start = st; pause = ps; Enable = en; auto_reload = ar;
        pulse = 1'b0;
        if (!rst) begin
            m_count = 0; m_reload = 0; m_mode = M_IDLE;
        end else if (ld) begin
            m_count = lv % 256; m_reload = lv % 256; m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (st && m_count != 0) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (ps) m_mode = M_PAUSED;
            else if (en && m_count == 1) begin
                pulse = 1'b1;
                if (ar) m_count = m_reload;
                else begin m_count = 0; m_mode = M_EXPIRED; end
            end else if (en) m_count = m_count - 1;
        end else if (m_mode == M_PAUSED) begin
            if (st && !ps) m_mode = M_RUN;
        end else begin
            if (st && m_reload != 0) begin m_count = m_reload; m_mode = M_RUN; end
        end
        e.count   = m_count[BITS-1:0];
        e.tc      = pulse;
        e.busy    = (m_mode == M_RUN) || (m_mode == M_PAUSED);
        e.expired = (m_mode == M_EXPIRED);
        e.tag     = tag;
        sb_q.push_back(e);
        @(negedge NEclk);
    endtask

    // Monitor: compare DUT outputs against the oldest prediction after each edge.
    always @(negedge NEclk) begin
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (count !== e.count || tc !== e.tc || busy !== e.busy ||
                expired !== e.expired) begin
                failures++;
                $display("FAIL %s: got count=%0d tc=%b busy=%b expired=%b, want count=%0d tc=%b busy=%b expired=%b",
                         e.tag, count, tc, busy, expired, e.count, e.tc, e.busy, e.expired);
            end
        end
    end

    initial begin
        int waited;
        reset = 1'b0; load = 1'b0; load_value = '0; start = 1'b0;
        pause = 1'b0; Enable = 1'b0; auto_reload = 1'b0;

        // args: rst ld lv st ps en ar
        step(0, 0, 0, 0, 0, 0, 0, "reset0");
        step(0, 0, 0, 1, 0, 1, 0, "reset1");

        // Reset clear mid-count, then start with reload 0 is ignored
        step(1, 1, 32'h20, 0, 0, 0, 0, "rc_load");
        step(1, 0, 0, 1, 0, 0, 0, "rc_start");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, 0, "rc_run");
        step(0, 0, 0, 1, 0, 1, 0, "rc_reset");
        for (int i = 0; i < 2; i++) step(1, 0, 0, 1, 0, 1, 0, "rc_start0");

        // One-shot of 5
        step(1, 1, 5, 0, 0, 0, 0, "os_load");
        step(1, 0, 0, 1, 0, 0, 0, "os_start");
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 1, 0, "os_run");

        // Auto-reload period 3
        step(1, 1, 3, 0, 0, 0, 1, "ar_load");
        step(1, 0, 0, 1, 0, 0, 1, "ar_start");
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 1, 1, "ar_run");

        // Enable gating, pause, resume
        step(1, 1, 4, 0, 0, 0, 0, "en_load");
        step(1, 0, 0, 1, 0, 0, 0, "en_start");
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, ((i % 2) == 0), 0, "en_gate");
        step(1, 0, 0, 0, 1, 1, 0, "pz_enter");
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 1, 0, "pz_hold");
        step(1, 0, 0, 1, 1, 1, 0, "pz_both");
        step(1, 0, 0, 1, 0, 0, 0, "pz_resume");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, 0, "pz_finish");

        // Priority: load+start in RUN, then reset with load
        step(1, 1, 10, 0, 0, 0, 0, "pr_load");
        step(1, 0, 0, 1, 0, 0, 0, "pr_start");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, 0, "pr_run");
        step(1, 1, 9, 1, 0, 1, 0, "pr_load_start");
        step(0, 1, 9, 1, 0, 1, 0, "pr_reset_load");

        // Restart from EXPIRED, then start in IDLE with count 0
        step(1, 1, 2, 0, 0, 0, 0, "rs_load");
        step(1, 0, 0, 1, 0, 0, 0, "rs_start");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, 0, "rs_run");
        step(1, 0, 0, 1, 0, 1, 0, "rs_restart");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, 0, "rs_rerun");
        step(1, 1, 0, 0, 0, 0, 0, "z_load0");
        step(1, 0, 0, 1, 0, 1, 0, "z_start0");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic r_rst, r_ld, r_st, r_ps, r_en, r_ar;
            int   r_lv;
            r_rst = ($urandom_range(0, 59) != 0);
            r_ld  = ($urandom_range(0, 14) == 0);
            r_st  = ($urandom_range(0, 3) == 0);
            r_ps  = ($urandom_range(0, 7) == 0);
            r_en  = ($urandom_range(0, 2) != 0);
            r_ar  = ($urandom_range(0, 1) == 1);
            r_lv  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                                : int'($urandom_range(0, 6));
            step(r_rst, r_ld, r_lv, r_st, r_ps, r_en, r_ar, "random");
        end

        // Drain the scoreboard within a bounded number of edges
        waited = 0;
        while (sb_q.size() > 0 && waited < 5) begin
            @(negedge NEclk);
            #2;
            waited++;
        end
        if (sb_q.size() > 0) begin
            failures++;
            $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable, restartable down-counter with a control FSM; the counterpart of the team's free-running up-counter.
- Software or sequencer loads a period, starts it, and receives a one-cycle terminal-count pulse `tc` on expiry.
- Optional auto-reload gives a periodic tick.
- `Enable` is the decrement qualifier, e.g. a prescaler strobe from an up-counter elsewhere in the design.

Parameters:
- BITS, 29, width of count, load_value and reload register.

Ports:
- NEclk  input  1  clock; all state updates on the falling edge.
- reset  input  1  synchronous, active-low reset; sampled on the falling edge of NEclk.
- Enable  input  1  decrement qualifier; count moves only when 1 in RUN.
- load  input  1  capture load_value into reload register and count.
- load_value  input  BITS  period to load.
- start  input  1  begin or resume counting.
- pause  input  1  suspend counting.
- auto_reload  input  1  on expiry, reload and keep running.
- count  output  BITS  current remaining count (registered).
- tc  output  1  one-cycle terminal-count pulse (registered).
- busy  output  1  1 in RUN or PAUSED.
- expired  output  1  1 in EXPIRED.

Behaviour:
- Interface: one clock (NEclk); reset is synchronous and active-low.
- Reset: when reset==0 at a falling edge:
  - count=0, reload register=0, tc=0.
  - state=IDLE, so busy=0 and expired=0.
  - Reset overrides all other inputs, including mid-count.
- Priority per edge: reset > load > start/pause > Enable decrement.
- tc defaults to 0 every edge; it is 1 only for the edge following an expiry event.
- Outputs are registered. A decrement, state change or tc appears one NEclk falling edge after the qualifying inputs.
- load (any state):
  - reload<=load_value, count<=load_value, state<=IDLE, tc<=0.
  - Aborts RUN or PAUSED; start in the same cycle is ignored.
- IDLE:
  - start with count!=0 -> RUN.
  - start with count==0 -> stay IDLE (ignored).
  - Enable is ignored in IDLE.
- RUN, with pause=1:
  - -> PAUSED; count holds, no decrement that edge.
- RUN, with pause=0 and Enable=1:
  - count>1: count<=count-1.
  - count==1: tc<=1.
    - If auto_reload==1: count<=reload, stay RUN.
    - Otherwise: count<=0, -> EXPIRED.
- RUN, with Enable=0: count holds.
- RUN: start is ignored.
- PAUSED:
  - start=1 and pause=0 -> RUN.
  - start and pause both 1 -> stay PAUSED.
  - Enable is ignored.
- EXPIRED:
  - count=0.
  - start with reload!=0: count<=reload, -> RUN.
  - start with reload==0: stay EXPIRED.
  - load -> IDLE.
- Period: with auto_reload=1, reload=N≥1 and Enable held at 1, tc asserts once every N edges.
- N=1: tc is high every edge and count stays 1.
- Width: plain BITS-bit decrement. count never wraps below 0, since the count==1 branch catches expiry.
- A count of 0 in RUN cannot occur.
- auto_reload is sampled only at the expiry edge; changing it mid-count is legal.
- Illegal or unused state encodings recover to IDLE on the next edge.

Test Plan (BITS=8):
- Reset clear:
  - Stimulus: load 0x20, start, then reset=0 for one edge mid-count.
  - Required: count=0, busy=0, expired=0, tc=0; start with reload 0 is ignored afterward.
- One-shot:
  - Stimulus: load 5, start, Enable=1.
  - Required: count 5,4,3,2,1,0 on successive edges; tc=1 exactly on the edge count becomes 0; expired=1, busy=0 thereafter; count holds 0.
- Auto-reload:
  - Stimulus: load 3, auto_reload=1, start, Enable=1 for 10 edges.
  - Required: count 3,2,1,3,2,1,3,...; tc high on every 3rd edge; expired stays 0.
- Enable gating and pause:
  - Stimulus: load 4, start, Enable toggling 1,0,1,0.
  - Required: count decrements only on Enable=1 edges.
  - Stimulus: pause at count=2, Enable=1 for 5 edges.
  - Required: count holds at 2, busy=1.
  - Stimulus: start with pause=0.
  - Required: resumes 1,0 then tc.
- Priority:
  - Stimulus: in RUN at count=7, load=1 with load_value 9 and start=1 same edge.
  - Required: count=9, state IDLE, busy=0.
  - Stimulus: reset=0 together with load.
  - Required: count=0.
- Restart from EXPIRED:
  - Stimulus: after one-shot of 2 expires, start.
  - Required: count=2, busy=1, expires again with one tc.
  - Stimulus: start in IDLE with count 0.
  - Required: no state change.
